// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared types and default parameter values for the
// multi-port register file (reg_file_mp) and its read-port slices.
//   state_e : clear-sweep FSM states (idle, sweeping, sweep-done pulse)
//   Def*    : default values for the DATA_W / ADDR_W / NUM_RD / ZERO_REG parameters
package reg_file_mp_pkg;

    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefAddrW   = 5;
    localparam int unsigned DefNumRd   = 2;
    localparam int unsigned DefZeroReg = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of reg_file_mp.
// Selects a register from the flattened array, optionally forwards a
// same-cycle accepted write (REG_FILE_MP_BYPASS_EN), and masks register 0
// when ZERO_REG is set.
// Ports:
//   rd_addr_i   : read address
//   regs_i      : flattened register array, entry k at [k*DATA_W +: DATA_W]
//   wr_a_*_i    : accepted write A (enable/address/data), bypass build only
//   wr_b_*_i    : accepted write B (enable/address/data), bypass build only
//   rd_data_o   : read data
// Macro: REG_FILE_MP_BYPASS_EN enables write-to-read forwarding.
module rf_read_port
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned ZERO_REG = DefZeroReg
) (
    input  logic [ADDR_W-1:0]               rd_addr_i,
    input  logic [(2**ADDR_W)*DATA_W-1:0]   regs_i,
`ifdef REG_FILE_MP_BYPASS_EN
    input  logic                            wr_a_en_i,
    input  logic [ADDR_W-1:0]               wr_a_addr_i,
    input  logic [DATA_W-1:0]               wr_a_data_i,
    input  logic                            wr_b_en_i,
    input  logic [ADDR_W-1:0]               wr_b_addr_i,
    input  logic [DATA_W-1:0]               wr_b_data_i,
`endif
    output logic [DATA_W-1:0]               rd_data_o
);

    always_comb begin
        rd_data_o = regs_i[int'(rd_addr_i) * int'(DATA_W) +: DATA_W];
`ifdef REG_FILE_MP_BYPASS_EN
        // B is checked last so it overrides A on an address collision.
        if (wr_a_en_i && (wr_a_addr_i == rd_addr_i)) begin
            rd_data_o = wr_a_data_i;
        end
        if (wr_b_en_i && (wr_b_addr_i == rd_addr_i)) begin
            rd_data_o = wr_b_data_i;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2**ADDR_W x DATA_W register file with NUM_RD combinational
// read ports, two write ports (B wins on collision) and a sequential clear
// sweep that zeroes one register per cycle.
// Ports:
//   clock, reset                  : clock, async active-high reset
//   read_reg / read_data          : packed read addresses / data, port k at slice k
//   write_reg_a/_data_a/_enable_a : write port A
//   write_reg_b/_data_b/_enable_b : write port B (priority over A)
//   clear_req                     : start a clear sweep (honoured only when idle)
//   busy                          : high while sweeping
//   clear_done                    : one-cycle pulse after the sweep
// Macro: REG_FILE_MP_BYPASS_EN forwards same-cycle accepted writes to reads.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned NUM_RD   = DefNumRd,
    parameter int unsigned ZERO_REG = DefZeroReg
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    input  logic [ADDR_W-1:0]          write_reg_a,
    input  logic [DATA_W-1:0]          write_data_a,
    input  logic                       write_enable_a,
    input  logic [ADDR_W-1:0]          write_reg_b,
    input  logic [DATA_W-1:0]          write_data_b,
    input  logic                       write_enable_b,
    input  logic                       clear_req,
    output logic                       busy,
    output logic                       clear_done
);

    localparam int unsigned Depth = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

    logic [DATA_W-1:0]        regs_q [Depth];
    logic [DATA_W-1:0]        regs_d [Depth];
    logic [Depth*DATA_W-1:0]  regs_flat;
    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic                     clr_en;
    logic                     wr_a_acc, wr_b_acc;

    // Writes are only accepted while idle; sweep and done cycles drop them.
    assign wr_a_acc = write_enable_a && (state_q == StIdle);
    assign wr_b_acc = write_enable_b && (state_q == StIdle);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;
        clear_done = 1'b0;
        clr_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                clear_done = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (clr_en) begin
            regs_d[cnt_q] = '0;
        end else begin
            if (wr_a_acc) begin
                regs_d[write_reg_a] = write_data_a;
            end
            if (wr_b_acc) begin
                regs_d[write_reg_b] = write_data_b;
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rd_addr_i   (read_reg[k*ADDR_W +: ADDR_W]),
            .regs_i      (regs_flat),
`ifdef REG_FILE_MP_BYPASS_EN
            .wr_a_en_i   (wr_a_acc),
            .wr_a_addr_i (write_reg_a),
            .wr_a_data_i (write_data_a),
            .wr_b_en_i   (wr_b_acc),
            .wr_b_addr_i (write_reg_b),
            .wr_b_data_i (write_data_b),
`endif
            .rd_data_o   (read_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp.
// A second instance with ZERO_REG=0 and one read port shares the write and
// clear inputs so register 0 behaviour can be compared in both settings.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic [2*AW-1:0] read_reg;
    logic [2*DW-1:0] read_data;
    logic [AW-1:0]   rd2_reg;
    logic [DW-1:0]   rd2_data;
    logic [AW-1:0]   write_reg_a, write_reg_b;
    logic [DW-1:0]   write_data_a, write_data_b;
    logic            write_enable_a, write_enable_b;
    logic            clear_req;
    logic            busy, clear_done, busy2, clear_done2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .read_reg       (read_reg),
        .read_data      (read_data),
        .write_reg_a    (write_reg_a),
        .write_data_a   (write_data_a),
        .write_enable_a (write_enable_a),
        .write_reg_b    (write_reg_b),
        .write_data_b   (write_data_b),
        .write_enable_b (write_enable_b),
        .clear_req      (clear_req),
        .busy           (busy),
        .clear_done     (clear_done)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(1), .ZERO_REG(0)) dut_nz (
        .clock          (clock),
        .reset          (reset),
        .read_reg       (rd2_reg),
        .read_data      (rd2_data),
        .write_reg_a    (write_reg_a),
        .write_data_a   (write_data_a),
        .write_enable_a (write_enable_a),
        .write_reg_b    (write_reg_b),
        .write_data_b   (write_data_b),
        .write_enable_b (write_enable_b),
        .clear_req      (clear_req),
        .busy           (busy2),
        .clear_done     (clear_done2)
    );

    // One write cycle: drive after a falling edge, release at the next one.
    task automatic write_cycle(input logic ea, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                               input logic eb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        @(negedge clock);
        write_enable_a = ea; write_reg_a = aa; write_data_a = da;
        write_enable_b = eb; write_reg_b = ab; write_data_b = db;
        @(negedge clock);
        write_enable_a = 1'b0;
        write_enable_b = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        read_reg = {p1, p0};
        #1;
    endtask

    task automatic fill_all();
        for (int a = 0; a < 32; a += 2) begin
            write_cycle(1'b1, AW'(a), 32'hFFFF_FFFF, 1'b1, AW'(a + 1), 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        read_reg = '0; rd2_reg = '0; clear_req = 1'b0;
        write_enable_a = 1'b0; write_enable_b = 1'b0;
        write_reg_a = '0; write_reg_b = '0; write_data_a = '0; write_data_b = '0;
        #2;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (clear_done !== 1'b0) begin
            miscompares++; $display("FAIL reset_done: got %b want 0", clear_done);
        end
        @(negedge clock);
        reset = 1'b0;
        set_rd(5'd5, 5'd31);
        vectors++;
        if (read_data[31:0] !== 32'h0) begin
            miscompares++; $display("FAIL reset_r5: got %h want 0", read_data[31:0]);
        end
        vectors++;
        if (read_data[63:32] !== 32'h0) begin
            miscompares++; $display("FAIL reset_r31: got %h want 0", read_data[63:32]);
        end
    endtask

    task automatic test_write_read();
        write_cycle(1'b1, 5'd5, 32'h0000_0001, 1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd4);
        vectors++;
        if (read_data[31:0] !== 32'h0000_0001) begin
            miscompares++; $display("FAIL wr_r5: got %h want 00000001", read_data[31:0]);
        end
        vectors++;
        if (read_data[63:32] !== 32'h0) begin
            miscompares++; $display("FAIL rd_r4: got %h want 0", read_data[63:32]);
        end
        write_cycle(1'b1, 5'd6, 32'h0BAD_0001, 1'b1, 5'd4, 32'hCAFE_F00D);
        set_rd(5'd4, 5'd6);
        vectors++;
        if (read_data[31:0] !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL wrb_r4: got %h want cafef00d", read_data[31:0]);
        end
        vectors++;
        if (read_data[63:32] !== 32'h0BAD_0001) begin
            miscompares++; $display("FAIL wra_r6: got %h want 0bad0001", read_data[63:32]);
        end
    endtask

    task automatic test_collision();
        write_cycle(1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'h5555_5555);
        set_rd(5'd7, 5'd7);
        vectors++;
        if (read_data[31:0] !== 32'h5555_5555) begin
            miscompares++; $display("FAIL collide_p0: got %h want 55555555", read_data[31:0]);
        end
        vectors++;
        if (read_data[63:32] !== 32'h5555_5555) begin
            miscompares++; $display("FAIL collide_p1: got %h want 55555555", read_data[63:32]);
        end
    endtask

    task automatic test_zero_reg();
        write_cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0);
        rd2_reg = 5'd0;
        #1;
        vectors++;
        if (read_data[31:0] !== 32'h0) begin
            miscompares++; $display("FAIL zero_r0: got %h want 0", read_data[31:0]);
        end
        vectors++;
        if (rd2_data !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL nozero_r0: got %h want ffffffff", rd2_data);
        end
        write_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_0042);
        set_rd(5'd0, 5'd0);
        vectors++;
        if (read_data[63:32] !== 32'h0) begin
            miscompares++; $display("FAIL zero_r0_b: got %h want 0", read_data[63:32]);
        end
        vectors++;
        if (rd2_data !== 32'h0000_0042) begin
            miscompares++; $display("FAIL nozero_r0_b: got %h want 00000042", rd2_data);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_same, exp_prio;
`ifdef REG_FILE_MP_BYPASS_EN
        exp_same = 32'h0000_BEEF;
        exp_prio = 32'h0000_0002;
`else
        exp_same = 32'h0000_1234;
        exp_prio = 32'h0000_0000;
`endif
        write_cycle(1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0, 32'h0);
        write_enable_a = 1'b1; write_reg_a = 5'd3; write_data_a = 32'h0000_BEEF;
        set_rd(5'd3, 5'd3);
        vectors++;
        if (read_data[31:0] !== exp_same) begin
            miscompares++; $display("FAIL bypass_r3: got %h want %h", read_data[31:0], exp_same);
        end
        @(negedge clock);
        write_enable_a = 1'b0;
        #1;
        vectors++;
        if (read_data[63:32] !== 32'h0000_BEEF) begin
            miscompares++; $display("FAIL after_r3: got %h want 0000beef", read_data[63:32]);
        end
        write_enable_a = 1'b1; write_reg_a = 5'd9; write_data_a = 32'h0000_0001;
        write_enable_b = 1'b1; write_reg_b = 5'd9; write_data_b = 32'h0000_0002;
        set_rd(5'd9, 5'd9);
        vectors++;
        if (read_data[31:0] !== exp_prio) begin
            miscompares++; $display("FAIL bypass_prio: got %h want %h", read_data[31:0], exp_prio);
        end
        @(negedge clock);
        write_enable_b = 1'b0;
        write_reg_a = 5'd0; write_data_a = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd9);
        vectors++;
        if (read_data[31:0] !== 32'h0) begin
            miscompares++; $display("FAIL bypass_r0: got %h want 0", read_data[31:0]);
        end
        vectors++;
        if (read_data[63:32] !== 32'h0000_0002) begin
            miscompares++; $display("FAIL after_r9: got %h want 00000002", read_data[63:32]);
        end
        @(negedge clock);
        write_enable_a = 1'b0;
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_idx = -1;
        fill_all();
        set_rd(5'd31, 5'd17);
        vectors++;
        if (read_data[31:0] !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL fill_r31: got %h want ffffffff", read_data[31:0]);
        end
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 11) begin
                clear_req = 1'b0; write_enable_a = 1'b0; write_enable_b = 1'b0;
            end
            if (i == 10) begin
                clear_req = 1'b1;
                write_enable_a = 1'b1; write_reg_a = 5'd2; write_data_a = 32'hDEAD_DEAD;
                write_enable_b = 1'b1; write_reg_b = 5'd3; write_data_b = 32'hBEEF_BEEF;
                read_reg = {5'd31, 5'd2};
            end
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (clear_done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (i == 10) begin
                vectors++;
                if (read_data[31:0] !== 32'h0) begin
                    miscompares++; $display("FAIL sweep_swept: got %h want 0", read_data[31:0]);
                end
                vectors++;
                if (read_data[63:32] !== 32'hFFFF_FFFF) begin
                    miscompares++;
                    $display("FAIL sweep_unswept: got %h want ffffffff", read_data[63:32]);
                end
            end
        end
        vectors++;
        if (busy_cnt != 32) begin
            miscompares++; $display("FAIL busy_cycles: got %0d want 32", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++; $display("FAIL done_pulses: got %0d want 1", done_cnt);
        end
        vectors++;
        if (done_idx != 32) begin
            miscompares++; $display("FAIL done_cycle: got %0d want 32", done_idx);
        end
        for (int a = 0; a < 32; a++) begin
            set_rd(AW'(a), AW'(31 - a));
            vectors++;
            if (read_data[31:0] !== 32'h0) begin
                miscompares++; $display("FAIL cleared_r%0d: got %h want 0", a, read_data[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_cnt = 0;
        int busy_after = 0;
        fill_all();
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 11) reset = 1'b0;
            if (i == 10) begin
                reset = 1'b1;
                read_reg = {5'd31, 5'd20};
                #1;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++; $display("FAIL abort_busy: got %b want 0", busy);
                end
                vectors++;
                if (read_data[31:0] !== 32'h0) begin
                    miscompares++; $display("FAIL abort_r20: got %h want 0", read_data[31:0]);
                end
                vectors++;
                if (read_data[63:32] !== 32'h0) begin
                    miscompares++; $display("FAIL abort_r31: got %h want 0", read_data[63:32]);
                end
            end else begin
                #1;
            end
            if (clear_done === 1'b1) done_cnt++;
            if (i >= 10 && busy === 1'b1) busy_after++;
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt);
        end
        vectors++;
        if (busy_after != 0) begin
            miscompares++; $display("FAIL abort_busy_after: got %0d cycles want 0", busy_after);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_bypass();
        test_clear();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, width of each register in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, number of read ports; legal range 1..4.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 always reads 0 and ignores writes.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 read_reg  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-008 read_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-009 write_reg_a / write_data_a / write_enable_a  in  ADDR_W / DATA_W / 1  write port A.
REQ-010 write_reg_b / write_data_b / write_enable_b  in  ADDR_W / DATA_W / 1  write port B.
REQ-011 clear_req  in  1  request for a sequential clear of all registers.
REQ-012 busy  out  1  high while a clear sweep is in progress.
REQ-013 clear_done  out  1  one-cycle pulse when a sweep completes.

Function
REQ-014 Reads SHALL be combinational: read_data[k] = reg[read_reg[k]] in the same cycle, for every port independently.
REQ-015 An enabled write SHALL update the register on the rising edge; the new value is visible to reads from the following cycle.
REQ-016 When both write ports target the same address in one cycle, port B SHALL win; port A's data is discarded.
REQ-017 When ZERO_REG=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0.
REQ-018 The FSM SHALL have states IDLE, CLEAR, DONE.
REQ-019 IDLE -> CLEAR on the rising edge where clear_req=1; the sweep counter loads 0.
REQ-020 In CLEAR, one register per cycle SHALL be written to 0 at the counter address, and the counter increments.
REQ-021 CLEAR -> DONE after exactly DEPTH CLEAR cycles (counter wrap from DEPTH-1); DONE -> IDLE after one cycle.
REQ-022 busy SHALL be 1 in CLEAR only; clear_done SHALL be 1 in DONE only.
REQ-023 Both write ports SHALL be ignored while busy=1 or in DONE.
REQ-024 clear_req SHALL be ignored outside IDLE; no request queuing.
REQ-025 During CLEAR, reads return current array contents: swept entries read 0, unswept entries keep old values.

Reset
REQ-026 Asserting reset SHALL immediately set all registers to 0, the FSM to IDLE, the counter to 0, and busy=0, clear_done=0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no clear_done pulse.

Configuration
REQ-028 Macro REG_FILE_MP_BYPASS_EN: when defined, a read whose address matches an enabled, accepted write in the same cycle SHALL return that write data, with port B taking priority over port A and ZERO_REG still applying.
REQ-029 Without REG_FILE_MP_BYPASS_EN, same-cycle reads SHALL return the pre-write value.

Structure
REQ-030 Package reg_file_mp_pkg SHALL hold the FSM state enum (IDLE, CLEAR, DONE) and the default parameter constants.
REQ-031 Sub-module rf_read_port SHALL implement one read port (array select, zero-reg masking, optional bypass); it is instantiated NUM_RD times.

Verification
REQ-032 Write A r5=0x0000_0001, next cycle read port 0 addr 5 -> 0x0000_0001; read port 1 addr 4 -> 0.
REQ-033 Same cycle write A r7=0xAAAA_AAAA and write B r7=0x5555_5555 -> r7 reads 0x5555_5555 next cycle.
REQ-034 Write r0=0xFFFF_FFFF with ZERO_REG=1 -> r0 reads 0; with ZERO_REG=0 -> reads 0xFFFF_FFFF.
REQ-035 Preload r3=0x1234; write A r3=0xBEEF while reading r3 in the same cycle -> 0xBEEF with the bypass macro, 0x1234 without it.
REQ-036 Fill all registers with 0xFFFF_FFFF, pulse clear_req -> busy high for exactly 32 cycles, clear_done one pulse, then all reads 0; a write issued mid-sweep leaves its target 0.
REQ-037 Start a sweep, assert reset at counter=10 -> busy=0 immediately, all registers 0, no clear_done pulse.
